// File: rtl/song_transmitter_pkg.sv
// song_transmitter shared types and constants.
// Optional echo checking is enabled with ECHO_CHECK_EN.
package song_transmitter_pkg;

  localparam int ADDR_W = 8;
  localparam int GAP_W  = 32;
  localparam logic [3:0] MISS_MAX = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
`ifdef ECHO_CHECK_EN
    ECHO,
    CMP,
`endif
    GAP
  } state_t;

  // Mismatch counter increment that sticks at MISS_MAX.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == MISS_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/song_transmitter_if.sv
// song_transmitter board-side and UART FIFO signals.
// Used unchanged whether or not ECHO_CHECK_EN is defined.
interface song_transmitter_if;

  logic [2:0] buttons;
  logic [1:0] switches;
  logic [5:0] leds;
  logic [7:0] ua_tx_din;
  logic       ua_tx_wr_en;
  logic       ua_tx_full;
  logic [7:0] ua_rx_dout;
  logic       ua_rx_empty;
  logic       ua_rx_rd_en;

  modport master (
    input  buttons, switches,
    input  ua_tx_full, ua_rx_dout, ua_rx_empty,
    output leds, ua_tx_din, ua_tx_wr_en, ua_rx_rd_en
  );

  modport slave (
    output buttons, switches,
    output ua_tx_full, ua_rx_dout, ua_rx_empty,
    input  leds, ua_tx_din, ua_tx_wr_en, ua_rx_rd_en
  );

endinterface

// File: rtl/song_transmitter_rom.sv
// song_rom: combinational melody store of ASCII notes.
// First character of SONG sits at address 0.
module song_rom #(
  parameter int SONG_LEN = 13,
  parameter logic [8*SONG_LEN-1:0] SONG = "EDCDEEEDDDEGG"
) (
  input  logic [7:0] address,
  output logic [7:0] data,
  output logic [7:0] last_address
);

  assign last_address = 8'(SONG_LEN - 1);

  // Select the addressed character; out of range reads as 0.
  always_comb begin
    data = 8'h00;
    for (int i = 0; i < SONG_LEN; i++) begin
      if (address == 8'(i)) begin
        data = SONG[8*(SONG_LEN-1-i) +: 8];
      end
    end
  end

endmodule

// File: rtl/song_transmitter.sv
// song_transmitter: paces ROM notes into the UART TX FIFO.
// Define ECHO_CHECK_EN to read back and count echo mismatches.
module song_transmitter
  import song_transmitter_pkg::*;
#(
  parameter int          CLOCK_FREQ   = 125_000_000,
  parameter int unsigned GAP_CYCLES   = CLOCK_FREQ / 4,
  parameter int unsigned ECHO_TIMEOUT = CLOCK_FREQ / 10,
  parameter int          SONG_LEN     = 13,
  parameter logic [8*SONG_LEN-1:0] SONG = "EDCDEEEDDDEGG"
) (
  input logic clk,
  input logic rst,
  song_transmitter_if.master bus
);

  localparam logic [GAP_W-1:0] TO_LAST = GAP_W'(ECHO_TIMEOUT - 1);

  state_t              r_state, w_state_n;
  logic [ADDR_W-1:0]   r_addr, w_addr_n;
  logic [7:0]          r_byte, w_byte_n;
  logic [GAP_W-1:0]    r_cnt, w_cnt_n;
  logic [3:0]          r_miss, w_miss_n;
  logic                r_stop, w_stop_n;
  logic                r_restart, w_restart_n;
  logic                r_stall, w_stall_n;
  logic                r_rd_en, w_rd_en_n;
  logic [7:0]          w_rom_data;
  logic [ADDR_W-1:0]   w_last;
  logic [GAP_W-1:0]    w_limit;
  logic                w_wr;
  logic                w_stop_any;
  logic                w_rst_any;
  logic [3:0]          w_led_hi;

  song_rom #(
    .SONG_LEN(SONG_LEN),
    .SONG(SONG)
  ) u_rom (
    .address(r_addr),
    .data(w_rom_data),
    .last_address(w_last)
  );

  assign w_limit = bus.switches[1] ? (GAP_W'(GAP_CYCLES) << 1)
                                   : GAP_W'(GAP_CYCLES);
  assign w_wr       = (r_state == SEND) && !bus.ua_tx_full;
  assign w_stop_any = r_stop | bus.buttons[0];
  assign w_rst_any  = r_restart | bus.buttons[1];

`ifdef ECHO_CHECK_EN
  assign w_led_hi        = r_miss;
  assign bus.ua_rx_rd_en = r_rd_en;
`else
  logic w_unused;
  assign w_led_hi        = r_addr[3:0];
  assign bus.ua_rx_rd_en = 1'b0;
  assign w_unused = ^{bus.ua_rx_dout, bus.ua_rx_empty,
                      TO_LAST, r_rd_en};
`endif

  assign bus.ua_tx_wr_en = w_wr;
  assign bus.ua_tx_din   = r_byte;
  assign bus.leds = {w_led_hi, r_stall, r_state != IDLE};

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_byte    <= '0;
      r_cnt     <= '0;
      r_miss    <= '0;
      r_stop    <= 1'b0;
      r_restart <= 1'b0;
      r_stall   <= 1'b0;
      r_rd_en   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_addr    <= w_addr_n;
      r_byte    <= w_byte_n;
      r_cnt     <= w_cnt_n;
      r_miss    <= w_miss_n;
      r_stop    <= w_stop_n;
      r_restart <= w_restart_n;
      r_stall   <= w_stall_n;
      r_rd_en   <= w_rd_en_n;
    end
  end

  // Next state, counters and latched stop/restart requests.
  always_comb begin
    w_state_n   = r_state;
    w_addr_n    = r_addr;
    w_byte_n    = r_byte;
    w_cnt_n     = '0;
    w_miss_n    = r_miss;
    w_stop_n    = w_stop_any;
    w_restart_n = w_rst_any;
    w_stall_n   = 1'b0;
    w_rd_en_n   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_stop_n    = 1'b0;
        w_restart_n = 1'b0;
        if (bus.buttons[1]) begin
          w_addr_n = '0;
          w_miss_n = '0;
        end
        if (bus.buttons[0]) w_state_n = FETCH;
      end
      FETCH: begin
        w_byte_n  = w_rom_data;
        w_state_n = SEND;
      end
      SEND: begin
        if (!w_wr) begin
          w_stall_n = 1'b1;
        end else begin
`ifdef ECHO_CHECK_EN
          w_state_n = ECHO;
`else
          w_state_n = GAP;
`endif
        end
      end
`ifdef ECHO_CHECK_EN
      ECHO: begin
        if (r_rd_en) begin
          w_state_n = CMP;
        end else if (!bus.ua_rx_empty) begin
          w_rd_en_n = 1'b1;
        end else if (r_cnt == TO_LAST) begin
          w_miss_n  = sat_inc(r_miss);
          w_state_n = GAP;
        end else begin
          w_cnt_n = r_cnt + 32'd1;
        end
      end
      CMP: begin
        if (bus.ua_rx_dout != r_byte) w_miss_n = sat_inc(r_miss);
        w_state_n = GAP;
      end
`endif
      GAP: begin
        w_stop_n    = 1'b0;
        w_restart_n = 1'b0;
        if (w_rst_any) begin
          w_addr_n  = '0;
          w_miss_n  = '0;
          w_state_n = IDLE;
        end else if (w_stop_any) begin
          w_state_n = IDLE;
        end else if (r_cnt == w_limit || bus.buttons[2]) begin
          if (r_addr == w_last) begin
            w_addr_n  = '0;
            w_state_n = bus.switches[0] ? FETCH : IDLE;
          end else begin
            w_addr_n  = r_addr + 8'd1;
            w_state_n = FETCH;
          end
        end else begin
          w_cnt_n = r_cnt + 32'd1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

endmodule
